// File: rtl/mm_bus_pkg.sv
// Shared main-memory bus definitions.
// Used by the port arbiter, the cache controllers and the memory model so all
// agree on the FSM state encoding, the operation codes and default widths.
package mm_bus_pkg;

    localparam int ADDR_W_DEF = 32;
    localparam int WORD_W_DEF = 32;
    localparam int LINE_W_DEF = 512;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } mm_state_e;

    typedef enum logic {
        OP_READ  = 1'b0,
        OP_WRITE = 1'b1
    } mm_op_e;

    // A requester asserting both read and write gets the write first, so a
    // dirty line is written back before its refill is fetched.
    function automatic mm_op_e pick_op(logic rd, logic wr);
        return (wr || !rd) ? OP_WRITE : OP_READ;
    endfunction

endpackage

// File: rtl/mm_port_arbiter_if.sv
// Bundle of the two requester ports and the main-memory port.
//   slave  : arbiter view (takes requests and memory responses, drives
//            completions and memory requests)
//   master : requester/memory-side view (the opposite directions)
// r0_* : requester 0 (D-cache), r1_* : requester 1 (I-cache / MMU walker)
// r_rdata : shared read-line return, valid only with r0_ready/r1_ready
// mm_*    : main-memory request/response
interface mm_port_arbiter_if
    import mm_bus_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int WORD_W = WORD_W_DEF,
    parameter int LINE_W = LINE_W_DEF
);
    logic [ADDR_W-1:0] r0_addr;
    logic [WORD_W-1:0] r0_wdata;
    logic              r0_read_req;
    logic              r0_write_req;
    logic              r0_ready;
    logic              r0_err;

    logic [ADDR_W-1:0] r1_addr;
    logic [WORD_W-1:0] r1_wdata;
    logic              r1_read_req;
    logic              r1_write_req;
    logic              r1_ready;
    logic              r1_err;

    logic [LINE_W-1:0] r_rdata;

    logic [ADDR_W-1:0] mm_addr;
    logic [WORD_W-1:0] mm_data_out;
    logic              mm_read_req;
    logic              mm_write_req;
    logic [LINE_W-1:0] mm_data_in;
    logic              mm_ready;

    modport slave (
        input  r0_addr, r0_wdata, r0_read_req, r0_write_req,
        input  r1_addr, r1_wdata, r1_read_req, r1_write_req,
        input  mm_data_in, mm_ready,
        output r0_ready, r0_err, r1_ready, r1_err, r_rdata,
        output mm_addr, mm_data_out, mm_read_req, mm_write_req
    );

    modport master (
        output r0_addr, r0_wdata, r0_read_req, r0_write_req,
        output r1_addr, r1_wdata, r1_read_req, r1_write_req,
        output mm_data_in, mm_ready,
        input  r0_ready, r0_err, r1_ready, r1_err, r_rdata,
        input  mm_addr, mm_data_out, mm_read_req, mm_write_req
    );

endinterface

// File: rtl/mm_port_arbiter_rr_arb2.sv
// Two-way round-robin pick.
//   pend       : pending vector, bit i = requester i wants the port
//   last_grant : requester that owned the previous completed transaction
//   any        : at least one requester pending
//   gnt        : chosen requester (meaningful only when any=1)
module rr_arb2
    import mm_bus_pkg::*;
(
    input  logic [1:0] pend,
    input  logic       last_grant,
    output logic       any,
    output logic       gnt
);
    always_comb begin
        any = |pend;
        gnt = 1'b0;
        if (&pend) begin
            // Tie: the one that did not go last.
            gnt = ~last_grant;
        end else begin
            gnt = pend[1];
        end
    end
endmodule

// File: rtl/mm_port_arbiter.sv
// Main-memory port arbiter for two cache controllers.
// Each transaction is granted round-robin in IDLE, issued to memory as a
// one-cycle request pulse, waited on (with a watchdog), and completed with a
// one-cycle ready pulse to the owning requester.
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   bus       : requester + memory signals (mm_port_arbiter_if.slave)
//   busy      : transaction in progress (state != IDLE)
//   grant_id  : owner of the current or last transaction
module mm_port_arbiter
    import mm_bus_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int WORD_W  = WORD_W_DEF,
    parameter int LINE_W  = LINE_W_DEF,
    parameter int TIMEOUT = 256
) (
    input  logic              clk,
    input  logic              rst,
    mm_port_arbiter_if.slave  bus,
    output logic              busy,
    output logic              grant_id
);
    localparam int CNT_W = $clog2(TIMEOUT);

    mm_state_e         state_q, state_d;
    mm_op_e            op_q, op_d;
    logic              gnt_q, gnt_d;
    logic              last_q, last_d;
    logic              err_q, err_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [WORD_W-1:0] wdata_q, wdata_d;
    logic [LINE_W-1:0] rdata_q, rdata_d;

    logic arb_any, arb_gnt;

    rr_arb2 u_arb (
        .pend       ({bus.r1_read_req | bus.r1_write_req,
                      bus.r0_read_req | bus.r0_write_req}),
        .last_grant (last_q),
        .any        (arb_any),
        .gnt        (arb_gnt)
    );

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        gnt_d   = gnt_q;
        last_d  = last_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (arb_any) begin
                    gnt_d   = arb_gnt;
                    err_d   = 1'b0;
                    addr_d  = arb_gnt ? bus.r1_addr  : bus.r0_addr;
                    wdata_d = arb_gnt ? bus.r1_wdata : bus.r0_wdata;
                    op_d    = arb_gnt ? pick_op(bus.r1_read_req, bus.r1_write_req)
                                      : pick_op(bus.r0_read_req, bus.r0_write_req);
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                // Counter tracks cycles elapsed since the request pulse, so
                // the abort lands TIMEOUT cycles after ISSUE.
                cnt_d   = CNT_W'(1);
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (bus.mm_ready) begin
                    if (op_q == OP_READ) rdata_d = bus.mm_data_in;
                    state_d = ST_RESP;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_RESP: begin
                last_d  = gnt_q;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            op_q    <= OP_READ;
            gnt_q   <= 1'b0;
            last_q  <= 1'b1;     // requester 0 wins the first tie
            err_q   <= 1'b0;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            gnt_q   <= gnt_d;
            last_q  <= last_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    // All outputs decode from flops only.
    assign bus.mm_addr      = addr_q;
    assign bus.mm_data_out  = wdata_q;
    assign bus.mm_read_req  = (state_q == ST_ISSUE) && (op_q == OP_READ);
    assign bus.mm_write_req = (state_q == ST_ISSUE) && (op_q == OP_WRITE);
    assign bus.r0_ready     = (state_q == ST_RESP) && !gnt_q;
    assign bus.r1_ready     = (state_q == ST_RESP) &&  gnt_q;
    assign bus.r0_err       = (state_q == ST_RESP) && !gnt_q && err_q;
    assign bus.r1_err       = (state_q == ST_RESP) &&  gnt_q && err_q;
    assign bus.r_rdata      = rdata_q;
    assign busy             = (state_q != ST_IDLE);
    assign grant_id         = gnt_q;

endmodule

// File: tb/tb_mm_port_arbiter.sv
module tb_mm_port_arbiter;
    import mm_bus_pkg::*;

    localparam int AW = 32, WW = 32, LW = 512, TO = 16;
    // Memory raises mm_ready this many cycles after the request-pulse cycle,
    // so a read completes 7 cycles after the arbiter samples it.
    localparam int MEM_LAT = 6;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic busy, grant_id;
    always #5 clk = ~clk;

    mm_port_arbiter_if #(.ADDR_W(AW), .WORD_W(WW), .LINE_W(LW)) bus ();

    mm_port_arbiter #(.ADDR_W(AW), .WORD_W(WW), .LINE_W(LW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .bus(bus), .busy(busy), .grant_id(grant_id)
    );

    typedef struct { mm_op_e op; logic [31:0] addr; logic [31:0] data; } pulse_t;
    typedef struct { logic id; logic err; logic chk; logic [31:0] word0; } rsp_t;
    typedef struct { int id; logic rd; logic wr; logic [31:0] addr; logic [31:0] wdata; int lat; } vec_t;

    pulse_t pq[$];
    rsp_t   rq[$];
    int tests = 0, fails = 0, cyc = 0;
    int pulse_cyc = 0, rdy_cyc = 0;
    logic saw_rdy = 0, saw_pulse = 0, rdy_id = 0;
    logic mem_on = 1, mem_drv = 0;
    int mem_cd = 0;
    logic [31:0] mem_addr = 0;
    logic [31:0] last_w0 = 0;

    function automatic logic [31:0] mem_word0(logic [31:0] a);
        return (a == 32'h0000_1040) ? 32'hDEAD_BEEF : (a ^ 32'h5A5A_0000);
    endfunction

    function automatic logic [LW-1:0] mem_line(logic [31:0] a);
        logic [LW-1:0] l;
        l = '0;
        for (int i = 0; i < LW/32; i++) l[i*32 +: 32] = mem_word0(a) + 32'(i);
        return l;
    endfunction

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(string name, string what);
        tests++;
        fails++;
        $display("FAIL %s: %s (cycle %0d)", name, what, cyc);
    endtask

    // One cycle: wait for the falling edge, run the memory model and the
    // scoreboard monitors.
    task automatic tick();
        pulse_t p;
        rsp_t   r;
        @(negedge clk);
        cyc++;
        saw_rdy   = 0;
        saw_pulse = 0;
        if (mem_drv) begin
            bus.mm_ready = 1'b0;
            mem_drv = 0;
        end
        if (mem_cd > 0) begin
            mem_cd--;
            if (mem_cd == 0) begin
                bus.mm_ready   = 1'b1;
                bus.mm_data_in = mem_line(mem_addr);
                mem_drv = 1;
            end
        end
        if (bus.mm_read_req || bus.mm_write_req) begin
            saw_pulse = 1;
            pulse_cyc = cyc;
            if (mem_on) begin
                mem_cd   = MEM_LAT;
                mem_addr = bus.mm_addr;
            end
            if (bus.mm_read_req && bus.mm_write_req) fail_now("pulse_excl", "read and write pulse together");
            if (pq.size() == 0) fail_now("unexpected_pulse", $sformatf("addr %0h", bus.mm_addr));
            else begin
                p = pq.pop_front();
                check("pulse_op", 64'(bus.mm_write_req), 64'(p.op == OP_WRITE));
                check("pulse_addr", 64'(bus.mm_addr), 64'(p.addr));
                if (p.op == OP_WRITE) check("pulse_data", 64'(bus.mm_data_out), 64'(p.data));
            end
        end
        if ((bus.r0_err && !bus.r0_ready) || (bus.r1_err && !bus.r1_ready))
            fail_now("err_without_ready", "err high outside ready cycle");
        if (bus.r0_ready || bus.r1_ready) begin
            saw_rdy = 1;
            rdy_cyc = cyc;
            rdy_id  = bus.r1_ready;
            if (bus.r0_ready && bus.r1_ready) fail_now("ready_excl", "both readies high");
            if (rq.size() == 0) fail_now("unexpected_ready", $sformatf("id %0d", bus.r1_ready));
            else begin
                r = rq.pop_front();
                check("ready_id", 64'(bus.r1_ready), 64'(r.id));
                check("ready_err", 64'(bus.r1_ready ? bus.r1_err : bus.r0_err), 64'(r.err));
                if (r.chk) check("rdata_w0", 64'(bus.r_rdata[31:0]), 64'(r.word0));
            end
        end
    endtask

    task automatic drive(int id, logic rd, logic wr, logic [31:0] a, logic [31:0] d);
        if (id == 0) begin
            bus.r0_read_req = rd; bus.r0_write_req = wr; bus.r0_addr = a; bus.r0_wdata = d;
        end else begin
            bus.r1_read_req = rd; bus.r1_write_req = wr; bus.r1_addr = a; bus.r1_wdata = d;
        end
    endtask

    task automatic wait_rdy(string name, output int lat);
        lat = 0;
        for (int k = 1; k <= 60; k++) begin
            tick();
            if (saw_rdy) begin
                lat = k;
                return;
            end
        end
        fail_now(name, "no ready within 60 cycles");
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0);
        tick();
        tick();
        rst = 1'b0;
    endtask

    vec_t vt[5];
    int   lat, n;

    initial begin
        bus.mm_ready   = 1'b0;
        bus.mm_data_in = '0;
        drive(0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0);

        // Reset values (sampled while rst is still high)
        tick();
        tick();
        check("rst_busy", 64'(busy), 0);
        check("rst_grant_id", 64'(grant_id), 0);
        check("rst_ready", 64'({bus.r0_ready, bus.r1_ready, bus.r0_err, bus.r1_err}), 0);
        check("rst_mm_req", 64'({bus.mm_read_req, bus.mm_write_req}), 0);
        check("rst_mm_addr", 64'(bus.mm_addr), 0);
        check("rst_rdata", 64'(bus.r_rdata[63:0]), 0);
        rst = 1'b0;

        // Single transactions, one requester at a time
        vt[0] = '{0, 1'b1, 1'b0, 32'h0000_1040, 32'h0,         8};
        vt[1] = '{1, 1'b0, 1'b1, 32'h0000_0200, 32'h1234_5678, 8};
        vt[2] = '{1, 1'b1, 1'b0, 32'h0000_4000, 32'h0,         8};
        vt[3] = '{0, 1'b0, 1'b1, 32'h0000_0080, 32'hCAFE_F00D, 8};
        vt[4] = '{0, 1'b1, 1'b0, 32'hFFFF_FFC0, 32'h0,         8};
        for (int i = 0; i < 5; i++) begin
            drive(vt[i].id, vt[i].rd, vt[i].wr, vt[i].addr, vt[i].wdata);
            pq.push_back('{vt[i].wr ? OP_WRITE : OP_READ, vt[i].addr, vt[i].wdata});
            // A write leaves r_rdata holding the last read line.
            rq.push_back('{1'(vt[i].id), 1'b0, 1'b1, vt[i].wr ? last_w0 : mem_word0(vt[i].addr)});
            if (!vt[i].wr) last_w0 = mem_word0(vt[i].addr);
            wait_rdy($sformatf("vec%0d", i), lat);
            check($sformatf("vec%0d_latency", i), 64'(lat), 64'(vt[i].lat));
            check($sformatf("vec%0d_grant_id", i), 64'(grant_id), 64'(vt[i].id));
            drive(vt[i].id, 0, 0, 0, 0);
            tick();
            check($sformatf("vec%0d_idle", i), 64'(busy), 0);
        end

        // Contention from reset: strict 0,1,0,1 alternation
        do_reset();
        drive(0, 1, 0, 32'h0000_3000, 0);
        drive(1, 1, 0, 32'h0000_7000, 0);
        for (int k = 0; k < 6; k++) begin
            pq.push_back('{OP_READ, (k % 2 == 0) ? 32'h0000_3000 : 32'h0000_7000, 32'h0});
            rq.push_back('{1'(k % 2), 1'b0, 1'b1,
                           mem_word0((k % 2 == 0) ? 32'h0000_3000 : 32'h0000_7000)});
        end
        n = 0;
        for (int k = 0; k < 200 && n < 6; k++) begin
            tick();
            if (saw_rdy) n++;
        end
        check("contention_count", 64'(n), 6);
        drive(0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0);
        last_w0 = mem_word0(32'h0000_7000);
        tick();

        // Same requester read+write: write first, then the read separately
        drive(0, 1, 1, 32'h0000_0080, 32'h1111_2222);
        pq.push_back('{OP_WRITE, 32'h0000_0080, 32'h1111_2222});
        rq.push_back('{1'b0, 1'b0, 1'b1, last_w0});
        pq.push_back('{OP_READ, 32'h0000_0080, 32'h0});
        rq.push_back('{1'b0, 1'b0, 1'b1, mem_word0(32'h0000_0080)});
        wait_rdy("rw_write", lat);
        drive(0, 1, 0, 32'h0000_0080, 32'h1111_2222);
        wait_rdy("rw_read", lat);
        check("rw_read_latency", 64'(lat), 9);
        drive(0, 0, 0, 0, 0);
        tick();

        // Timeout: memory silent, abort TO cycles after ISSUE
        mem_on = 0;
        drive(0, 1, 0, 32'h0000_5000, 0);
        pq.push_back('{OP_READ, 32'h0000_5000, 32'h0});
        rq.push_back('{1'b0, 1'b1, 1'b0, 32'h0});
        wait_rdy("timeout", lat);
        check("timeout_cycles", 64'(rdy_cyc - pulse_cyc), 64'(TO));
        drive(0, 0, 0, 0, 0);
        for (int k = 0; k < 5; k++) tick();
        bus.mm_ready   = 1'b1;       // late response, must be ignored
        bus.mm_data_in = mem_line(32'h0000_BAD0);
        mem_drv = 1;
        tick();
        check("late_ready_busy", 64'(busy), 0);
        tick();
        check("late_ready_busy2", 64'(busy), 0);
        mem_on = 1;
        drive(0, 1, 0, 32'h0000_5040, 0);
        pq.push_back('{OP_READ, 32'h0000_5040, 32'h0});
        rq.push_back('{1'b0, 1'b0, 1'b1, mem_word0(32'h0000_5040)});
        wait_rdy("after_timeout", lat);
        check("after_timeout_latency", 64'(lat), 8);
        drive(0, 0, 0, 0, 0);
        tick();

        // Reset mid-WAIT: transaction abandoned, post-reset tie goes to 0
        mem_on = 0;
        drive(0, 1, 0, 32'h0000_6000, 0);
        pq.push_back('{OP_READ, 32'h0000_6000, 32'h0});
        n = 0;
        for (int k = 0; k < 10 && !saw_pulse; k++) tick();
        if (!saw_pulse) fail_now("rst_wait_pulse", "no request pulse");
        tick();
        tick();
        tick();
        check("pre_rst_busy", 64'(busy), 1);
        rst = 1'b1;
        drive(1, 1, 0, 32'h0000_6100, 0);
        tick();
        rst = 1'b0;
        check("post_rst_busy", 64'(busy), 0);
        check("post_rst_grant_id", 64'(grant_id), 0);
        mem_on = 1;
        pq.push_back('{OP_READ, 32'h0000_6000, 32'h0});
        rq.push_back('{1'b0, 1'b0, 1'b1, mem_word0(32'h0000_6000)});
        pq.push_back('{OP_READ, 32'h0000_6100, 32'h0});
        rq.push_back('{1'b1, 1'b0, 1'b1, mem_word0(32'h0000_6100)});
        wait_rdy("post_rst_first", lat);
        check("post_rst_tie", 64'(rdy_id), 0);
        drive(0, 0, 0, 0, 0);
        wait_rdy("post_rst_second", lat);
        check("post_rst_second_id", 64'(rdy_id), 1);
        drive(1, 0, 0, 0, 0);
        tick();
        tick();

        check("pulse_queue_empty", 64'(pq.size()), 0);
        check("rsp_queue_empty", 64'(rq.size()), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
